// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int SEL_W      = 4;
    // Scoreboard addresses are held at a fixed width so the entry type does not depend on REG_AW.
    localparam int RD_MAX_W   = 8;

    localparam logic [SEL_W-1:0] FWD_RF = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_t;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } sb_entry_t;

    function automatic logic [SEL_W-1:0] stage_sel(input int k);
        return SEL_W'(k + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side and ALU-side signal bundle of the forwarding / hazard unit.
interface fwd_hazard_unit_if
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    logic                    flush;
    logic                    id_valid;
    logic [REG_AW-1:0]       id_rs;
    logic [REG_AW-1:0]       id_rt;
    logic                    id_uses_rs;
    logic                    id_uses_rt;
    logic [REG_AW-1:0]       id_rd;
    logic                    id_we;
    logic                    id_is_load;
    logic [DATA_W-1:0]       rf_rs_data;
    logic [DATA_W-1:0]       rf_rt_data;
    logic [DEPTH*DATA_W-1:0] stg_data;
    logic [DATA_W-1:0]       op_a;
    logic [DATA_W-1:0]       op_b;
    logic [SEL_W-1:0]        fwd_sel_a;
    logic [SEL_W-1:0]        fwd_sel_b;
    logic                    stall;
    logic                    issue;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        hazard_cnt;

    modport master (
        output flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_we, id_is_load,
               rf_rs_data, rf_rt_data, stg_data,
        input  op_a, op_b, fwd_sel_a, fwd_sel_b, stall, issue, stall_cnt, hazard_cnt
    );

    modport slave (
        input  flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_we, id_is_load,
               rf_rs_data, rf_rt_data, stg_data,
        output op_a, op_b, fwd_sel_a, fwd_sel_b, stall, issue, stall_cnt, hazard_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_src_select.sv
// Per-operand priority match over the scoreboard: youngest matching writer wins,
// forwarded if its data is ready, otherwise flagged as a load-use hazard.
module fwd_src_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic [REG_AW-1:0]       src_i,
    input  logic                    uses_i,
    input  logic [DATA_W-1:0]       rf_data_i,
    input  logic [DEPTH*DATA_W-1:0] stg_data_i,
    input  sb_entry_t [DEPTH-1:0]   sb_i,
    output logic [DATA_W-1:0]       op_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    hazard_o
);

    logic [RD_MAX_W-1:0] src_ext;
    logic                src_live;
    logic                found;

    assign src_ext  = RD_MAX_W'(src_i);
    assign src_live = uses_i && (src_i != '0);

    always_comb begin
        op_o     = rf_data_i;
        sel_o    = FWD_RF;
        hazard_o = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && src_live && sb_i[k].valid && (sb_i[k].rd == src_ext)) begin
                found = 1'b1;
                sel_o = stage_sel(k);
                // A load younger than LOAD_LAT has no data yet; operand is left as don't-care.
                if (!sb_i[k].is_load || (k >= LOAD_LAT)) begin
                    op_o = stg_data_i[k*DATA_W +: DATA_W];
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall control between the ID/EX register read and the ALU.
//   state | meaning
//   RUN   | ID instruction issues unless a load-use hazard is seen
//   STALL | hazard held; bubbles age the load until its data is ready
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave hz_if
);

    fsm_t                  state_q, state_d;
    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      hazard_cnt_q, hazard_cnt_d;
    logic [DATA_W-1:0]     op_a, op_b;
    logic [SEL_W-1:0]      sel_a, sel_b;
    logic                  hazard_a, hazard_b;
    logic                  stall, issue, hazard_evt;

    fwd_src_select #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
    ) u_sel_a (
        .src_i      (hz_if.id_rs),
        .uses_i     (hz_if.id_uses_rs),
        .rf_data_i  (hz_if.rf_rs_data),
        .stg_data_i (hz_if.stg_data),
        .sb_i       (sb_q),
        .op_o       (op_a),
        .sel_o      (sel_a),
        .hazard_o   (hazard_a)
    );

    fwd_src_select #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
    ) u_sel_b (
        .src_i      (hz_if.id_rt),
        .uses_i     (hz_if.id_uses_rt),
        .rf_data_i  (hz_if.rf_rt_data),
        .stg_data_i (hz_if.stg_data),
        .sb_i       (sb_q),
        .op_o       (op_b),
        .sel_o      (sel_b),
        .hazard_o   (hazard_b)
    );

    assign stall = hz_if.id_valid && !hz_if.flush && (hazard_a || hazard_b);
    assign issue = hz_if.id_valid && !stall && !hz_if.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall)  state_d = STALL;
            STALL:   if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (hz_if.flush) state_d = RUN;
    end

    always_comb begin
        hazard_evt = (state_q == RUN) && stall;
    end

    // A stall pushes an invalid entry, so the blocking load keeps ageing toward LOAD_LAT.
    always_comb begin
        sb_d = '0;
        if (!hz_if.flush) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0].valid   = issue && hz_if.id_we && (hz_if.id_rd != '0);
            sb_d[0].rd      = RD_MAX_W'(hz_if.id_rd);
            sb_d[0].is_load = hz_if.id_is_load;
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hazard_evt && (hazard_cnt_q != '1)) begin
            hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q         <= '0;
            stall_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            sb_q         <= sb_d;
            stall_cnt_q  <= stall_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign hz_if.op_a       = op_a;
    assign hz_if.op_b       = op_b;
    assign hz_if.fwd_sel_a  = sel_a;
    assign hz_if.fwd_sel_b  = sel_b;
    assign hz_if.stall      = stall;
    assign hz_if.issue      = issue;
    assign hz_if.stall_cnt  = stall_cnt_q;
    assign hz_if.hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_LAT=1 with 16-bit counters, LOAD_LAT=2 with
// 4-bit counters) driven by shared stimulus and compared against a list-based pipeline model.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        flush, id_valid, id_uses_rs, id_uses_rt, id_we, id_is_load;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] rf_rs_data, rf_rt_data;
    logic [31:0] stg [3];

    int n_checks;
    int n_err;

    fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .CNT_W(16)) ifa ();
    fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .CNT_W(4))  ifb ();

    fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .hz_if(ifa));
    fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .LOAD_LAT(2), .CNT_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .hz_if(ifb));

    assign ifa.flush = flush;           assign ifb.flush = flush;
    assign ifa.id_valid = id_valid;     assign ifb.id_valid = id_valid;
    assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
    assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
    assign ifa.id_uses_rs = id_uses_rs; assign ifb.id_uses_rs = id_uses_rs;
    assign ifa.id_uses_rt = id_uses_rt; assign ifb.id_uses_rt = id_uses_rt;
    assign ifa.id_rd = id_rd;           assign ifb.id_rd = id_rd;
    assign ifa.id_we = id_we;           assign ifb.id_we = id_we;
    assign ifa.id_is_load = id_is_load; assign ifb.id_is_load = id_is_load;
    assign ifa.rf_rs_data = rf_rs_data; assign ifb.rf_rs_data = rf_rs_data;
    assign ifa.rf_rt_data = rf_rt_data; assign ifb.rf_rt_data = rf_rt_data;
    assign ifa.stg_data = {stg[2], stg[1], stg[0]};
    assign ifb.stg_data = {stg[2], stg[1], stg[0]};

    logic [31:0] d_op_a [2], d_op_b [2];
    logic [3:0]  d_sel_a [2], d_sel_b [2];
    logic        d_stall [2], d_issue [2];
    logic [15:0] d_scnt [2], d_hcnt [2];

    assign d_op_a[0] = ifa.op_a;         assign d_op_a[1] = ifb.op_a;
    assign d_op_b[0] = ifa.op_b;         assign d_op_b[1] = ifb.op_b;
    assign d_sel_a[0] = ifa.fwd_sel_a;   assign d_sel_a[1] = ifb.fwd_sel_a;
    assign d_sel_b[0] = ifa.fwd_sel_b;   assign d_sel_b[1] = ifb.fwd_sel_b;
    assign d_stall[0] = ifa.stall;       assign d_stall[1] = ifb.stall;
    assign d_issue[0] = ifa.issue;       assign d_issue[1] = ifb.issue;
    assign d_scnt[0] = ifa.stall_cnt;    assign d_scnt[1] = {12'd0, ifb.stall_cnt};
    assign d_hcnt[0] = ifa.hazard_cnt;   assign d_hcnt[1] = {12'd0, ifb.hazard_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: list of in-flight writers per instance, index 0 = youngest.
    typedef struct {
        bit valid;
        int rd;
        bit ld;
    } ent_t;

    ent_t pipe [2][3];
    int   ll [2];
    int   cmax [2];
    int   m_scnt [2];
    int   m_hcnt [2];
    bit   m_prev [2];
    bit   m_stall [2];
    bit   m_issue [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) pipe[i][k] = '{valid: 1'b0, rd: 0, ld: 1'b0};
            m_scnt[i] = 0;
            m_hcnt[i] = 0;
            m_prev[i] = 1'b0;
        end
    endfunction

    function automatic void resolve(input int inst, input logic [4:0] src, input logic uses,
                                    input logic [31:0] rf, output logic [31:0] op,
                                    output int sel, output bit haz);
        op  = rf;
        sel = 0;
        haz = 1'b0;
        if (uses && src != 5'd0) begin
            for (int k = 0; k < 3; k++) begin
                if (pipe[inst][k].valid && pipe[inst][k].rd == int'(src)) begin
                    sel = k + 1;
                    if (pipe[inst][k].ld && k < ll[inst]) haz = 1'b1;
                    else op = stg[k];
                    break;
                end
            end
        end
    endfunction

    function automatic void advance(input int i);
        if (flush) begin
            for (int k = 0; k < 3; k++) pipe[i][k].valid = 1'b0;
        end else begin
            for (int k = 2; k > 0; k--) pipe[i][k] = pipe[i][k-1];
            pipe[i][0] = '{valid: m_issue[i] && id_we && id_rd != 5'd0, rd: int'(id_rd), ld: id_is_load};
        end
        if (m_stall[i]) begin
            if (m_scnt[i] < cmax[i]) m_scnt[i]++;
            if (!m_prev[i] && m_hcnt[i] < cmax[i]) m_hcnt[i]++;
        end
        m_prev[i] = m_stall[i];
    endfunction

    // Called one time unit after a rising edge; checks combinational outputs, clocks, checks counters.
    task automatic step();
        logic [31:0] ea, eb;
        int          sa, sb;
        bit          ha, hb;
        #2;
        for (int i = 0; i < 2; i++) begin
            resolve(i, id_rs, id_uses_rs, rf_rs_data, ea, sa, ha);
            resolve(i, id_rt, id_uses_rt, rf_rt_data, eb, sb, hb);
            m_stall[i] = id_valid && !flush && (ha || hb);
            m_issue[i] = id_valid && !m_stall[i] && !flush;
            check_val($sformatf("sel_a[%0d]", i), 32'(d_sel_a[i]), 32'(sa));
            check_val($sformatf("sel_b[%0d]", i), 32'(d_sel_b[i]), 32'(sb));
            if (!ha) check_val($sformatf("op_a[%0d]", i), d_op_a[i], ea);
            if (!hb) check_val($sformatf("op_b[%0d]", i), d_op_b[i], eb);
            check_val($sformatf("stall[%0d]", i), 32'(d_stall[i]), 32'(m_stall[i]));
            check_val($sformatf("issue[%0d]", i), 32'(d_issue[i]), 32'(m_issue[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) advance(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("stall_cnt[%0d]", i), 32'(d_scnt[i]), 32'(m_scnt[i]));
            check_val($sformatf("hazard_cnt[%0d]", i), 32'(d_hcnt[i]), 32'(m_hcnt[i]));
        end
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int rd, input bit we, input bit ld);
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_rd      = 5'(rd);
        id_we      = we;
        id_is_load = ld;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        id_valid = 1'b0;
        #1;
        model_reset();
        check_val("rst_scnt_a", 32'(ifa.stall_cnt), 32'd0);
        check_val("rst_hcnt_b", 32'(ifb.hazard_cnt), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        ll[0] = 1;     ll[1] = 2;
        cmax[0] = 65535; cmax[1] = 15;
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 3, 4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        rf_rs_data = 32'h1234;
        rf_rt_data = 32'h5678;
        for (int k = 0; k < 3; k++) stg[k] = 32'hA0 + 32'(k);
        model_reset();
        #12;
        check_val("reset_op_a", ifa.op_a, 32'h1234);
        check_val("reset_op_b", ifb.op_b, 32'h5678);
        check_val("reset_sel_a", 32'(ifa.fwd_sel_a), 32'd0);
        check_val("reset_stall", 32'(ifa.stall), 32'd0);
        check_val("reset_hcnt", 32'(ifa.hazard_cnt), 32'd0);
        id_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add r3 ; add r4,r3,r1
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 3, 1, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        stg[0] = 32'h55;
        #1;
        check_val("fwd_ex_op_a", ifa.op_a, 32'h55);
        check_val("fwd_ex_sel_a", 32'(ifa.fwd_sel_a), 32'd1);
        check_val("fwd_ex_stall", 32'(ifa.stall), 32'd0);
        step();

        // lw r5 ; add r6,r5,r5
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        stg[1] = 32'hDEAD;
        #1;
        check_val("lu_stall_a", 32'(ifa.stall), 32'd1);
        check_val("lu_stall_b", 32'(ifb.stall), 32'd1);
        step();
        #1;
        check_val("lu_rel_stall_a", 32'(ifa.stall), 32'd0);
        check_val("lu_rel_op_a", ifa.op_a, 32'hDEAD);
        check_val("lu_rel_op_b", ifa.op_b, 32'hDEAD);
        check_val("lu_rel_sel_a", 32'(ifa.fwd_sel_a), 32'd2);
        check_val("lu2_stall_b", 32'(ifb.stall), 32'd1);
        step();
        id_valid = 1'b0;
        step();
        check_val("lu_hcnt_a", 32'(ifa.hazard_cnt), 32'd1);
        check_val("lu_scnt_a", 32'(ifa.stall_cnt), 32'd1);
        check_val("lu2_scnt_b", 32'(ifb.stall_cnt), 32'd2);
        check_val("lu2_hcnt_b", 32'(ifb.hazard_cnt), 32'd1);

        // r7 written at stages 0 and 2, r0 write between
        do_reset();
        set_id(1'b1, 1, 0, 1'b1, 1'b0, 7, 1'b1, 1'b0);
        step();
        set_id(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 7, 1'b1, 1'b0);
        step();
        set_id(1'b1, 7, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0);
        rf_rt_data = 32'd0;
        stg[0] = 32'h70; stg[1] = 32'h71; stg[2] = 32'h72;
        #1;
        check_val("young_op_a", ifa.op_a, 32'h70);
        check_val("young_sel_a", 32'(ifa.fwd_sel_a), 32'd1);
        check_val("r0_op_b", ifa.op_b, 32'd0);
        check_val("r0_sel_b", 32'(ifa.fwd_sel_b), 32'd0);
        step();

        // flush during a stall
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        rf_rs_data = 32'h0F0F;
        #1;
        check_val("fl_pre_stall", 32'(ifa.stall), 32'd1);
        flush = 1'b1;
        #1;
        check_val("fl_stall_a", 32'(ifa.stall), 32'd0);
        check_val("fl_stall_b", 32'(ifb.stall), 32'd0);
        check_val("fl_issue_a", 32'(ifa.issue), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check_val("fl_after_sel_a", 32'(ifa.fwd_sel_a), 32'd0);
        check_val("fl_after_sel_b", 32'(ifb.fwd_sel_b), 32'd0);
        check_val("fl_after_op_a", ifa.op_a, 32'h0F0F);
        step();

        // repeated load-use pairs: 4-bit counters of instance B saturate
        do_reset();
        for (int p = 0; p < 20; p++) begin
            set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
            step();
            set_id(1'b1, 5, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0);
            for (int c = 0; c < 3; c++) step();
        end
        check_val("sat_hcnt_b", 32'(ifb.hazard_cnt), 32'd15);
        check_val("sat_scnt_b", 32'(ifb.stall_cnt), 32'd15);
        check_val("run_hcnt_a", 32'(ifa.hazard_cnt), 32'd20);
        check_val("run_scnt_a", 32'(ifa.stall_cnt), 32'd20);

        // async reset in the middle of a stall
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        #1;
        check_val("mid_pre_stall_b", 32'(ifb.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_stall_b", 32'(ifb.stall), 32'd0);
        check_val("mid_rst_scnt_b", 32'(ifb.stall_cnt), 32'd0);
        check_val("mid_rst_hcnt_a", 32'(ifa.hazard_cnt), 32'd0);
        check_val("mid_rst_sel_a", 32'(ifa.fwd_sel_a), 32'd0);
        model_reset();
        id_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            id_valid   = ($urandom_range(0, 9) < 8);
            flush      = ($urandom_range(0, 19) == 0);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 7));
            id_uses_rs = ($urandom_range(0, 3) != 0);
            id_uses_rt = ($urandom_range(0, 1) != 0);
            id_we      = ($urandom_range(0, 4) != 0);
            id_is_load = ($urandom_range(0, 2) == 0);
            rf_rs_data = $urandom;
            rf_rt_data = $urandom;
            for (int k = 0; k < 3; k++) stg[k] = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
